// File: rtl/metronome_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : metronome_pkg
// Purpose  : Shared types and constant helpers for the metronome timing core.
//            Holds the engine state encoding, the beat-index width derivation
//            and the beat threshold of the phase accumulator.
// Revision : 1.0 - initial parametrised metronome engine
// ============================================================================
package metronome_pkg;

    // Engine state; the one-bit width is fixed on purpose.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width needed to hold beat indices 0..max_beats.
    function automatic int beat_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    // Counter width able to hold 0..n-1, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator value at which one beat has elapsed: adding bpm every clock,
    // a beat occurs every 60*CLK_HZ/bpm clocks.
    function automatic longint unsigned beat_threshold(input longint unsigned clk_hz);
        return 64'd60 * clk_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/metronome_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : metronome_audio_if
// Purpose  : Sample handshake between the metronome engine and the audio
//            controller.
// Signals  : sample_ready - controller can accept a sample this cycle
//            sample_out   - signed click sample
//            sample_write - write strobe, sample_out is taken this cycle
// Modports : master (engine side), slave (audio controller side)
// Revision : 1.0 - initial parametrised metronome engine
// ============================================================================
interface metronome_audio_if #(
    parameter int SAMPLE_W = 32
) ();

    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_write;

    modport master (
        input  sample_ready,
        output sample_out,
        output sample_write
    );

    modport slave (
        output sample_ready,
        input  sample_out,
        input  sample_write
    );

endinterface
`default_nettype wire

// File: rtl/metronome_engine_click_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : click_tone_gen
// Purpose  : Square-wave click synthesiser. Counts written samples, toggles
//            polarity every half-period (shorter half-period for accented
//            clicks) and registers the outgoing sample.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            i_click_active - value the click gate takes at this edge
//            i_retrigger    - a beat occurs at this edge
//            i_accent       - the beat at this edge is accented
//            i_sample_write - the current sample is consumed this cycle
//            o_sample_out   - registered signed click sample
// Revision : 1.0 - initial parametrised metronome engine
// ============================================================================
module click_tone_gen
    import metronome_pkg::*;
#(
    parameter int                  HALF_NORM = 48,
    parameter int                  HALF_ACC  = 24,
    parameter int                  SAMPLE_W  = 32,
    parameter logic [SAMPLE_W-1:0] AMP       = 'h0800_0000
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_click_active,
    input  wire logic                i_retrigger,
    input  wire logic                i_accent,
    input  wire logic                i_sample_write,
    output logic      [SAMPLE_W-1:0] o_sample_out
);

    localparam int TONE_W = cnt_width((HALF_NORM > HALF_ACC) ? HALF_NORM : HALF_ACC);
    localparam logic [TONE_W-1:0]   c_norm_last = TONE_W'(HALF_NORM - 1);
    localparam logic [TONE_W-1:0]   c_acc_last  = TONE_W'(HALF_ACC - 1);
    localparam logic [SAMPLE_W-1:0] c_amp_pos   = AMP;
    localparam logic [SAMPLE_W-1:0] c_amp_neg   = -AMP;

    logic [TONE_W-1:0] r_cnt;
    logic              r_pol;     // 1 = positive half
    logic              r_accent;  // pitch latched at the last beat
    logic [TONE_W-1:0] w_last;

    assign w_last = r_accent ? c_acc_last : c_norm_last;

    // The sample register is loaded with the value matching the click gate's
    // next state, so sample_out and click_active change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_pol        <= 1'b1;
            r_accent     <= 1'b0;
            o_sample_out <= '0;
        end else if (i_retrigger) begin
            // Every click starts on a fresh positive half-period.
            r_cnt        <= '0;
            r_pol        <= 1'b1;
            r_accent     <= i_accent;
            o_sample_out <= c_amp_pos;
        end else if (!i_click_active) begin
            r_cnt        <= '0;
            r_pol        <= 1'b1;
            o_sample_out <= '0;
        end else if (i_sample_write && (r_cnt == w_last)) begin
            r_cnt        <= '0;
            r_pol        <= ~r_pol;
            o_sample_out <= r_pol ? c_amp_neg : c_amp_pos;
        end else begin
            // Phase only advances when the controller consumes a sample.
            if (i_sample_write) begin
                r_cnt <= r_cnt + TONE_W'(1);
            end
            o_sample_out <= r_pol ? c_amp_pos : c_amp_neg;
        end
    end

endmodule
`default_nettype wire

// File: rtl/metronome_engine.sv
`default_nettype none
// ============================================================================
// Module   : metronome_engine
// Purpose  : Parametrised metronome timing core. A phase accumulator turns a
//            clamped BPM value into beat strobes with no long-term drift;
//            beats are counted within a measure, downbeats are flagged as
//            accents, and each beat opens a click window carrying a
//            square-wave tone for the audio controller.
// Ports    : CLOCK_50          - system clock
//            iRST_N            - asynchronous active-low reset
//            run               - 1 = running, 0 = stopped
//            bpm               - requested tempo (clamped MIN_BPM..MAX_BPM)
//            beats_per_measure - beats per measure, 0 treated as 1
//            accent_en         - accent beat index 0
//            beat_pulse        - one-cycle strobe per beat
//            accent_pulse      - one-cycle strobe on accented beats
//            beat_idx          - 0-based beat index within the measure
//            click_active      - click window gate (also drives the LEDs)
//            audio             - sample handshake to the audio controller
// Revision : 1.0 - initial parametrised metronome engine
// ============================================================================
module metronome_engine
    import metronome_pkg::*;
#(
    parameter int                  CLK_HZ       = 50_000_000,
    parameter int                  ACC_W        = 32,
    parameter int                  BPM_W        = 9,
    parameter int                  MIN_BPM      = 30,
    parameter int                  MAX_BPM      = 300,
    parameter int                  MAX_BEATS    = 16,
    parameter int                  CLICK_CYCLES = 2_500_000,
    parameter int                  HALF_NORM    = 48,
    parameter int                  HALF_ACC     = 24,
    parameter int                  SAMPLE_W     = 32,
    parameter logic [SAMPLE_W-1:0] AMP          = 'h0800_0000,
    localparam int                 BEAT_W       = beat_width(MAX_BEATS)
) (
    input  wire logic              CLOCK_50,
    input  wire logic              iRST_N,
    input  wire logic              run,
    input  wire logic [BPM_W-1:0]  bpm,
    input  wire logic [BEAT_W-1:0] beats_per_measure,
    input  wire logic              accent_en,
    output logic                   beat_pulse,
    output logic                   accent_pulse,
    output logic      [BEAT_W-1:0] beat_idx,
    output logic                   click_active,
    metronome_audio_if.master      audio
);

    localparam logic [ACC_W-1:0]   c_threshold  = ACC_W'(beat_threshold(64'(CLK_HZ)));
    localparam int                 CLICK_W      = cnt_width(CLICK_CYCLES);
    localparam logic [CLICK_W-1:0] c_click_load = CLICK_W'(CLICK_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start;
    logic                w_stop;
    logic                w_running;
    logic                w_sample_write;

    logic [BPM_W-1:0]    w_bpm_eff;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_sum;
    logic                w_hit;
    logic                w_beat;

    logic [BEAT_W-1:0]   w_meas;
    logic [BEAT_W-1:0]   w_idx_inc;
    logic [BEAT_W-1:0]   w_idx_adv;
    logic [BEAT_W-1:0]   w_idx_new;
    logic                w_accent;

    logic [CLICK_W-1:0]  r_click_cnt;
    logic                w_click_next;
    logic [SAMPLE_W-1:0] w_sample_out;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = run ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_next = run ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start        = 1'b0;
        w_stop         = 1'b0;
        w_running      = 1'b0;
        w_sample_write = 1'b0;
        case (r_state)
            ST_IDLE: w_start = run;
            ST_RUN: begin
                w_stop         = ~run;
                w_running      = run;
                w_sample_write = audio.sample_ready;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------- tempo path
    always_comb begin
        if (bpm < BPM_W'(MIN_BPM)) begin
            w_bpm_eff = BPM_W'(MIN_BPM);
        end else if (bpm > BPM_W'(MAX_BPM)) begin
            w_bpm_eff = BPM_W'(MAX_BPM);
        end else begin
            w_bpm_eff = bpm;
        end
    end

    assign w_sum = r_acc + ACC_W'(w_bpm_eff);
    assign w_hit = (w_sum >= c_threshold);
    // A falling run suppresses any beat due at the same edge.
    assign w_beat = w_start | (w_running & w_hit);

    // ------------------------------------------------------- beat counting
    assign w_meas    = (beats_per_measure == '0) ? BEAT_W'(1) : beats_per_measure;
    assign w_idx_inc = beat_idx + BEAT_W'(1);
    // ">=" also catches a measure shortened below the current index.
    assign w_idx_adv = (w_idx_inc >= w_meas) ? '0 : w_idx_inc;
    assign w_idx_new = w_start ? '0 : w_idx_adv;
    assign w_accent  = w_beat & accent_en & (w_idx_new == '0);

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_acc        <= '0;
            beat_pulse   <= 1'b0;
            accent_pulse <= 1'b0;
            beat_idx     <= '0;
        end else begin
            beat_pulse   <= w_beat;
            accent_pulse <= w_accent;
            if (w_running) begin
                // Keep the remainder so the beat period has no drift.
                r_acc <= w_hit ? (w_sum - c_threshold) : w_sum;
                if (w_hit) begin
                    beat_idx <= w_idx_adv;
                end
            end else begin
                r_acc    <= '0;
                beat_idx <= '0;
            end
        end
    end

    // ---------------------------------------------------------- click gate
    // A beat reloads the window even when it coincides with expiry.
    assign w_click_next = w_beat | (click_active & ~w_stop & (r_click_cnt != '0));

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            click_active <= 1'b0;
            r_click_cnt  <= '0;
        end else begin
            click_active <= w_click_next;
            if (w_beat) begin
                r_click_cnt <= c_click_load;
            end else if (w_click_next) begin
                r_click_cnt <= r_click_cnt - CLICK_W'(1);
            end else begin
                r_click_cnt <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- tone
    click_tone_gen #(
        .HALF_NORM (HALF_NORM),
        .HALF_ACC  (HALF_ACC),
        .SAMPLE_W  (SAMPLE_W),
        .AMP       (AMP)
    ) u_click_tone_gen (
        .clk            (CLOCK_50),
        .rst_n          (iRST_N),
        .i_click_active (w_click_next),
        .i_retrigger    (w_beat),
        .i_accent       (w_accent),
        .i_sample_write (w_sample_write),
        .o_sample_out   (w_sample_out)
    );

    assign audio.sample_out   = w_sample_out;
    assign audio.sample_write = w_sample_write;

endmodule
`default_nettype wire

// File: tb/tb_metronome_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_metronome_engine
// Purpose  : Directed self-checking bench for metronome_engine with a scaled
//            clock (CLK_HZ=100, threshold 6000), CLICK_CYCLES=40,
//            HALF_NORM=4 and HALF_ACC=2.
// Revision : 1.0 - initial parametrised metronome engine
// ============================================================================
module tb_metronome_engine;

    localparam int          BEAT_W = 5;
    localparam logic [31:0] c_pos  = 32'h0800_0000;
    localparam logic [31:0] c_neg  = 32'hF800_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic [8:0]        bpm;
    logic [BEAT_W-1:0] meas;
    logic              accent_en;
    logic              beat_pulse;
    logic              accent_pulse;
    logic [BEAT_W-1:0] beat_idx;
    logic              click_active;

    int n_checks = 0;
    int n_fail   = 0;
    int orphan   = 0;
    int q_cyc[$];
    int q_idx[$];
    int q_acc[$];

    metronome_audio_if #(.SAMPLE_W(32)) audio_if ();

    metronome_engine #(
        .CLK_HZ       (100),
        .ACC_W        (32),
        .BPM_W        (9),
        .MIN_BPM      (30),
        .MAX_BPM      (300),
        .MAX_BEATS    (16),
        .CLICK_CYCLES (40),
        .HALF_NORM    (4),
        .HALF_ACC     (2),
        .SAMPLE_W     (32),
        .AMP          (32'h0800_0000)
    ) dut (
        .CLOCK_50          (clk),
        .iRST_N            (rst_n),
        .run               (run),
        .bpm               (bpm),
        .beats_per_measure (meas),
        .accent_en         (accent_en),
        .beat_pulse        (beat_pulse),
        .accent_pulse      (accent_pulse),
        .beat_idx          (beat_idx),
        .click_active      (click_active),
        .audio             (audio_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go_idle();
        run = 1'b0;
        tick_n(2);
    endtask

    // Runs n cycles after the current one, logging every beat (cycle 1 is the
    // first cycle after the edge that samples run).
    task automatic collect(input int n);
        q_cyc.delete(); q_idx.delete(); q_acc.delete();
        for (int c = 1; c <= n; c++) begin
            tick();
            if (beat_pulse === 1'b1) begin
                q_cyc.push_back(c);
                q_idx.push_back(int'(beat_idx));
                q_acc.push_back(int'(accent_pulse));
            end else if (accent_pulse !== 1'b0) begin
                orphan++;
            end
        end
    endtask

    function automatic logic [31:0] tone(input int writes, input int half);
        return (((writes / half) % 2) == 0) ? c_pos : c_neg;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; bpm = 9'd60; meas = 5'd4; accent_en = 1'b0;
        audio_if.sample_ready = 1'b1;
        tick_n(3);
        n_checks++; if (beat_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_beat: got %b want 0", beat_pulse); end
        n_checks++; if (accent_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_accent: got %b want 0", accent_pulse); end
        n_checks++; if (beat_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", beat_idx); end
        n_checks++; if (click_active !== 1'b0) begin n_fail++; $display("FAIL reset_click: got %b want 0", click_active); end
        n_checks++; if (audio_if.sample_out !== 32'h0) begin n_fail++; $display("FAIL reset_sample: got %h want 0", audio_if.sample_out); end
        n_checks++; if (audio_if.sample_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", audio_if.sample_write); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (beat_pulse !== 1'b0) begin n_fail++; $display("FAIL idle_beat: got %b want 0", beat_pulse); end
    endtask

    task automatic test_period();
        go_idle();
        bpm = 9'd60; meas = 5'd4; accent_en = 1'b1; run = 1'b1;
        collect(401);
        n_checks++; if (q_cyc.size() != 5) begin n_fail++; $display("FAIL period_count: got %0d want 5", q_cyc.size()); end
        for (int i = 0; i < q_cyc.size() && i < 5; i++) begin
            n_checks++; if (q_cyc[i] != 1 + 100 * i) begin n_fail++; $display("FAIL period_cycle[%0d]: got %0d want %0d", i, q_cyc[i], 1 + 100 * i); end
            n_checks++; if (q_idx[i] != i % 4) begin n_fail++; $display("FAIL period_idx[%0d]: got %0d want %0d", i, q_idx[i], i % 4); end
            n_checks++; if (q_acc[i] != ((i % 4 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL period_accent[%0d]: got %0d want %0d", i, q_acc[i], (i % 4 == 0) ? 1 : 0); end
        end
    endtask

    task automatic test_accent();
        int exp_idx[5] = '{0, 1, 2, 0, 1};
        // Three beats per measure, accents on.
        go_idle();
        bpm = 9'd300; meas = 5'd3; accent_en = 1'b1; orphan = 0; run = 1'b1;
        collect(81);
        n_checks++; if (q_cyc.size() != 5) begin n_fail++; $display("FAIL acc3_count: got %0d want 5", q_cyc.size()); end
        for (int i = 0; i < q_cyc.size() && i < 5; i++) begin
            n_checks++; if (q_idx[i] != exp_idx[i]) begin n_fail++; $display("FAIL acc3_idx[%0d]: got %0d want %0d", i, q_idx[i], exp_idx[i]); end
            n_checks++; if (q_acc[i] != ((exp_idx[i] == 0) ? 1 : 0)) begin n_fail++; $display("FAIL acc3_accent[%0d]: got %0d want %0d", i, q_acc[i], (exp_idx[i] == 0) ? 1 : 0); end
        end
        // Accents disabled.
        go_idle();
        accent_en = 1'b0; run = 1'b1;
        collect(41);
        n_checks++; if (q_cyc.size() != 3) begin n_fail++; $display("FAIL noacc_count: got %0d want 3", q_cyc.size()); end
        for (int i = 0; i < q_acc.size(); i++) begin
            n_checks++; if (q_acc[i] != 0) begin n_fail++; $display("FAIL noacc_accent[%0d]: got %0d want 0", i, q_acc[i]); end
        end
        // Zero beats per measure behaves as one.
        go_idle();
        meas = 5'd0; accent_en = 1'b1; run = 1'b1;
        collect(41);
        n_checks++; if (q_cyc.size() != 3) begin n_fail++; $display("FAIL meas0_count: got %0d want 3", q_cyc.size()); end
        for (int i = 0; i < q_cyc.size(); i++) begin
            n_checks++; if (q_idx[i] != 0) begin n_fail++; $display("FAIL meas0_idx[%0d]: got %0d want 0", i, q_idx[i]); end
            n_checks++; if (q_acc[i] != 1) begin n_fail++; $display("FAIL meas0_accent[%0d]: got %0d want 1", i, q_acc[i]); end
        end
        n_checks++; if (orphan != 0) begin n_fail++; $display("FAIL accent_without_beat: got %0d want 0", orphan); end
    endtask

    task automatic test_clamp();
        go_idle();
        bpm = 9'd10; meas = 5'd4; accent_en = 1'b0; run = 1'b1;
        collect(201);
        n_checks++; if (q_cyc.size() != 2) begin n_fail++; $display("FAIL clamp_low_count: got %0d want 2", q_cyc.size()); end
        if (q_cyc.size() >= 2) begin
            n_checks++; if (q_cyc[1] - q_cyc[0] != 200) begin n_fail++; $display("FAIL clamp_low_period: got %0d want 200", q_cyc[1] - q_cyc[0]); end
        end
        go_idle();
        bpm = 9'd500; run = 1'b1;
        collect(41);
        n_checks++; if (q_cyc.size() != 3) begin n_fail++; $display("FAIL clamp_high_count: got %0d want 3", q_cyc.size()); end
        if (q_cyc.size() >= 2) begin
            n_checks++; if (q_cyc[1] - q_cyc[0] != 20) begin n_fail++; $display("FAIL clamp_high_period: got %0d want 20", q_cyc[1] - q_cyc[0]); end
        end
    endtask

    task automatic test_click_tone();
        audio_if.sample_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            int half = (pass == 0) ? 4 : 2;
            logic [31:0] exp_s;
            go_idle();
            bpm = 9'd60; meas = (pass == 0) ? 5'd4 : 5'd1; accent_en = (pass == 1); run = 1'b1;
            for (int c = 1; c <= 60; c++) begin
                tick();
                exp_s = (c <= 40) ? tone(c - 1, half) : 32'h0;
                n_checks++; if (click_active !== (c <= 40)) begin n_fail++; $display("FAIL click_gate p%0d c%0d: got %b want %b", pass, c, click_active, (c <= 40)); end
                n_checks++; if (audio_if.sample_out !== exp_s) begin n_fail++; $display("FAIL click_sample p%0d c%0d: got %h want %h", pass, c, audio_if.sample_out, exp_s); end
            end
        end
    endtask

    task automatic test_ready_stall();
        int writes = 0;
        logic [31:0] exp_s;
        go_idle();
        bpm = 9'd60; meas = 5'd4; accent_en = 1'b0; run = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            audio_if.sample_ready = (c % 3 != 0);
            #1;
            exp_s = (c <= 40) ? tone(writes, 4) : 32'h0;
            n_checks++; if (audio_if.sample_out !== exp_s) begin n_fail++; $display("FAIL stall_sample c%0d: got %h want %h", c, audio_if.sample_out, exp_s); end
            n_checks++; if (audio_if.sample_write !== (c % 3 != 0)) begin n_fail++; $display("FAIL stall_write c%0d: got %b want %b", c, audio_if.sample_write, (c % 3 != 0)); end
            if (c % 3 != 0) writes++;
        end
        audio_if.sample_ready = 1'b1;
    endtask

    task automatic test_retrigger();
        for (int pass = 0; pass < 2; pass++) begin
            int period = (pass == 0) ? 20 : 40;
            logic [31:0] exp_s;
            go_idle();
            bpm = (pass == 0) ? 9'd300 : 9'd150; meas = 5'd4; accent_en = 1'b0; run = 1'b1;
            for (int c = 1; c <= 100; c++) begin
                tick();
                exp_s = tone((c - 1) % period, 4);
                n_checks++; if (click_active !== 1'b1) begin n_fail++; $display("FAIL retrig_gate p%0d c%0d: got %b want 1", pass, c, click_active); end
                n_checks++; if (audio_if.sample_out !== exp_s) begin n_fail++; $display("FAIL retrig_sample p%0d c%0d: got %h want %h", pass, c, audio_if.sample_out, exp_s); end
            end
        end
    endtask

    task automatic test_stop();
        go_idle();
        bpm = 9'd60; meas = 5'd4; accent_en = 1'b0; run = 1'b1;
        tick_n(110);
        n_checks++; if (beat_idx !== 5'd1) begin n_fail++; $display("FAIL stop_pre_idx: got %0d want 1", beat_idx); end
        n_checks++; if (click_active !== 1'b1) begin n_fail++; $display("FAIL stop_pre_click: got %b want 1", click_active); end
        run = 1'b0;
        tick();
        n_checks++; if (click_active !== 1'b0) begin n_fail++; $display("FAIL stop_click: got %b want 0", click_active); end
        n_checks++; if (audio_if.sample_out !== 32'h0) begin n_fail++; $display("FAIL stop_sample: got %h want 0", audio_if.sample_out); end
        n_checks++; if (beat_idx !== 5'd0) begin n_fail++; $display("FAIL stop_idx: got %0d want 0", beat_idx); end
        n_checks++; if (audio_if.sample_write !== 1'b0) begin n_fail++; $display("FAIL stop_write: got %b want 0", audio_if.sample_write); end
        // Run falls on the edge where a beat is due: no beat may appear.
        go_idle();
        run = 1'b1;
        tick_n(100);
        run = 1'b0;
        tick();
        n_checks++; if (beat_pulse !== 1'b0) begin n_fail++; $display("FAIL stop_vs_beat_pulse: got %b want 0", beat_pulse); end
        n_checks++; if (click_active !== 1'b0) begin n_fail++; $display("FAIL stop_vs_beat_click: got %b want 0", click_active); end
    endtask

    task automatic test_async_reset();
        go_idle();
        bpm = 9'd300; meas = 5'd4; accent_en = 1'b1; run = 1'b1;
        tick_n(30);
        n_checks++; if (beat_idx !== 5'd1) begin n_fail++; $display("FAIL areset_pre_idx: got %0d want 1", beat_idx); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (beat_idx !== 5'd0) begin n_fail++; $display("FAIL areset_idx: got %0d want 0", beat_idx); end
        n_checks++; if (click_active !== 1'b0) begin n_fail++; $display("FAIL areset_click: got %b want 0", click_active); end
        n_checks++; if (audio_if.sample_out !== 32'h0) begin n_fail++; $display("FAIL areset_sample: got %h want 0", audio_if.sample_out); end
        n_checks++; if (audio_if.sample_write !== 1'b0) begin n_fail++; $display("FAIL areset_write: got %b want 0", audio_if.sample_write); end
        n_checks++; if (beat_pulse !== 1'b0 || accent_pulse !== 1'b0) begin n_fail++; $display("FAIL areset_pulses: got %b%b want 00", beat_pulse, accent_pulse); end
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++; if (beat_pulse !== 1'b1) begin n_fail++; $display("FAIL restart_beat: got %b want 1", beat_pulse); end
        n_checks++; if (beat_idx !== 5'd0) begin n_fail++; $display("FAIL restart_idx: got %0d want 0", beat_idx); end
        n_checks++; if (accent_pulse !== 1'b1) begin n_fail++; $display("FAIL restart_accent: got %b want 1", accent_pulse); end
        n_checks++; if (audio_if.sample_out !== c_pos) begin n_fail++; $display("FAIL restart_sample: got %h want %h", audio_if.sample_out, c_pos); end
    endtask

    initial begin
        test_reset();
        test_period();
        test_accent();
        test_clamp();
        test_click_tone();
        test_ready_stall();
        test_retrigger();
        test_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
